fan_driver: RTL and testbench
=============================

FAN_DRIVER -- requirements
Module: fan_driver

Interface
REQ-001 The block SHALL have the parameter RAMP_DIV, default 1024, meaning clocks per duty ramp step (minimum 1).
REQ-002 The block SHALL have the parameter MIN_OFF, default 4096, meaning the minimum compressor off-time in clocks (anti-short-cycle).
REQ-003 The block SHALL have the port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have the port fan_speed, input, 3, the fan speed command from the AC controller.
REQ-006 The block SHALL have the port fan_heat, input, 8, the outlet temperature setpoint in degrees C; 0 means no cooling demand.
REQ-007 The block SHALL have the port coil_temp, input, 7, the measured outlet temperature in degrees C.
REQ-008 The block SHALL have the port fan_pwm, output, 1, the registered fan PWM drive.
REQ-009 The block SHALL have the port duty, output, 8, the current ramped duty value.
REQ-010 The block SHALL have the port compressor_on, output, 1, the registered compressor enable.
REQ-011 The block SHALL have the port ramping, output, 1, which is high while duty differs from the target.

Function
REQ-012 The target duty SHALL be mapped from fan_speed as 0->0, 1->64, 2->128, 3->192, and 4 to 7->255, sampled every clock.
REQ-013 A prescaler SHALL count 0..RAMP_DIV-1 and emit a one-clock tick at RAMP_DIV-1; on a tick, duty moves 1 toward the target (+1 or -1), and is unchanged when equal.
REQ-014 A target change SHALL not reset the prescaler; the direction of the next step follows the target at that tick.
REQ-015 duty SHALL saturate within 0..255 with no wrap.
REQ-016 The ramp state machine SHALL have the states OFF, RAMP_UP, RUN and RAMP_DOWN, with these transitions:
- OFF->RAMP_UP when the target is greater than 0.
- RAMP_UP/RAMP_DOWN->RUN when duty equals the target and the target is not 0.
- RAMP_DOWN->OFF when duty equals 0 and the target is 0.
- RUN->RAMP_UP or RAMP_DOWN when the target is above or below duty.
- A direction reversal mid-ramp switches directly between RAMP_UP and RAMP_DOWN.
REQ-017 ramping SHALL be high exactly in RAMP_UP and RAMP_DOWN.
REQ-018 An 8-bit PWM counter SHALL free-run 0..255 and wrap.
REQ-019 duty SHALL be latched into the PWM comparator only when the counter equals 255, so PWM periods are glitch-free.
REQ-020 fan_pwm SHALL be registered as (cnt < latched_duty), with latched_duty 255 forcing constant 1 and latched_duty 0 giving constant 0.
REQ-021 The compressor turn-on condition SHALL require all of the following at the same clock:
- fan_speed is not 0.
- fan_heat is not 0.
- duty is at least 64.
- coil_temp zero-extended to 8 bits is greater than fan_heat.
- the off-timer is expired.
REQ-022 The compressor SHALL turn off when fan_speed equals 0, fan_heat equals 0, or coil_temp+1 is at most fan_heat (1 degree C hysteresis, computed in 8 bits).
REQ-023 Compressor turn-off SHALL take effect on the next clock and have priority over the ramp, so the compressor is off before duty falls below 64.
REQ-024 Each on->off transition of compressor_on SHALL load the off-timer with MIN_OFF-1; the timer decrements to 0 and is expired at 0.
REQ-025 If the turn-on conditions are met before the off-timer expires, compressor_on SHALL stay 0 and turn on on the clock after expiry.
REQ-026 The latency from an input change to compressor_on SHALL be 1 clock, and from duty to fan_pwm SHALL be at most 257 clocks.

Reset
REQ-027 While reset is high, the block SHALL set state OFF, duty 0, latched_duty 0, the PWM counter 0, the prescaler 0, fan_pwm 0, compressor_on 0 and ramping 0.
REQ-028 While reset is high, the off-timer SHALL be set to expired, so there is no lockout after power-up.
REQ-029 Reset asserted mid-ramp or with the compressor on SHALL force all reset values on the next clock, with no off-time enforced.

Structure
REQ-030 The shared package ac_pkg SHALL hold the AC mode constants (OFF/AUTOMATIC/FAST_COOL/ECO), the fan_speed-to-duty table, the ramp state encoding and the duty threshold 64.
REQ-031 The design SHALL contain one sub-module, pwm_gen, holding the PWM counter, the duty latch and the fan_pwm register.

Verification (RAMP_DIV=4, MIN_OFF=32)
REQ-032 Reset, then fan_speed=2 -> duty reaches 128 after 512 clocks, state is RUN, ramping is 0, and the fan_pwm high time is 128 per 256 clocks after the next latch.
REQ-033 fan_speed=4, fan_heat=20, coil_temp=25 from OFF -> compressor_on rises on the clock after duty reaches 64 (256 clocks).
REQ-034 With the compressor on, set coil_temp=19 -> compressor_on is 0 the next clock; then set coil_temp=25 within 31 clocks -> compressor_on stays 0 until the timer expires, then rises.
REQ-035 At duty 100 while ramping up, change fan_speed to 1 -> state goes to RAMP_DOWN, duty falls to 64 and then RUN.
REQ-036 At duty 255 with the compressor on, set fan_speed=0 -> compressor_on is 0 the next clock, duty reaches 0 after 1020 clocks, then state is OFF.
REQ-037 At duty 255 with the compressor on, assert reset for 1 clock -> all outputs are 0; then fan_speed=4 with demand -> the compressor starts at duty 64 with no lockout.

Source files
------------

// File: rtl/ac_pkg.sv
// ac_pkg: shared AC mode constants, fan_speed-to-duty table, ramp state encoding and compressor duty threshold
package ac_pkg;
    typedef enum logic [1:0] {AC_OFF, AC_AUTOMATIC, AC_FAST_COOL, AC_ECO} ac_mode_e;
    typedef enum logic [1:0] {ST_OFF, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN} ramp_state_e;
    localparam logic [7:0] DUTY_THRESH = 8'd64;
    localparam logic [7:0] DUTY_TABLE [8] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd255, 8'd255, 8'd255, 8'd255};
endpackage

// File: rtl/fan_driver_pwm_gen.sv
// pwm_gen: free-running 8-bit PWM with duty latched at counter wrap
// Ports: clk/reset (sync, active-high), duty in, registered fan_pwm out.
module pwm_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       fan_pwm
);
    logic [7:0] cnt_q, cnt_d, latched_q, latched_d;
    logic       pwm_q, pwm_d;
    always_comb begin
        cnt_d     = cnt_q + 8'd1;
        latched_d = (cnt_q == 8'd255) ? duty : latched_q;
        // 255 would otherwise drop low for the single cnt==255 slot
        pwm_d     = (latched_q == 8'd255) || (cnt_q < latched_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 8'd0;
            latched_q <= 8'd0;
            pwm_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
            pwm_q     <= pwm_d;
        end
    end
    assign fan_pwm = pwm_q;
endmodule

// File: rtl/fan_driver.sv
// fan_driver: ramped fan duty with PWM drive and anti-short-cycle compressor control
// Ports: clk/reset (sync, active-high); fan_speed, fan_heat (setpoint), coil_temp in;
//        fan_pwm, duty, compressor_on, ramping out (all registered).
module fan_driver
    import ac_pkg::*;
#(
    parameter int RAMP_DIV = 1024,
    parameter int MIN_OFF  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] fan_speed,
    input  logic [7:0] fan_heat,
    input  logic [6:0] coil_temp,
    output logic       fan_pwm,
    output logic [7:0] duty,
    output logic       compressor_on,
    output logic       ramping
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TW = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
    ramp_state_e   state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    duty_q, duty_d, target;
    logic          comp_q, comp_d, ramp_q, ramp_d, tick, turn_on, turn_off;
    always_comb begin
        target   = DUTY_TABLE[fan_speed];
        tick     = (pre_q == PW'(RAMP_DIV - 1));
        pre_d    = tick ? '0 : pre_q + 1'b1;
        duty_d   = !tick ? duty_q : (duty_q < target) ? duty_q + 8'd1 : (duty_q > target) ? duty_q - 8'd1 : duty_q;
        // Decided on the post-step duty so state and ramping line up with duty on the same clock
        state_d  = (state_q == ST_OFF && target == 8'd0) ? ST_OFF :
                   (target > duty_d) ? ST_RAMP_UP :
                   (target < duty_d) ? ST_RAMP_DOWN :
                   (target == 8'd0) ? ST_OFF : ST_RUN;
        ramp_d   = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
        turn_on  = (fan_speed != 3'd0) && (fan_heat != 8'd0) && (duty_q >= DUTY_THRESH) &&
                   ({1'b0, coil_temp} > fan_heat) && (timer_q == '0);
        turn_off = (fan_speed == 3'd0) || (fan_heat == 8'd0) || (({1'b0, coil_temp} + 8'd1) <= fan_heat);
        comp_d   = comp_q ? !turn_off : turn_on;
        timer_d  = (comp_q && !comp_d) ? TW'(MIN_OFF - 1) : (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            pre_q   <= '0;
            duty_q  <= 8'd0;
            timer_q <= '0;
            comp_q  <= 1'b0;
            ramp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            duty_q  <= duty_d;
            timer_q <= timer_d;
            comp_q  <= comp_d;
            ramp_q  <= ramp_d;
        end
    end
    pwm_gen u_pwm (
        .clk     (clk),
        .reset   (reset),
        .duty    (duty_q),
        .fan_pwm (fan_pwm)
    );
    assign duty          = duty_q;
    assign compressor_on = comp_q;
    assign ramping       = ramp_q;
endmodule

// File: tb/tb_fan_driver.sv
// tb_fan_driver: per-cycle model comparison plus directed literal checks for fan_driver
module tb_fan_driver;
    localparam int RD = 4;
    localparam int MO = 32;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fan_speed = 3'd0;
    logic [7:0] fan_heat = 8'd0;
    logic [6:0] coil_temp = 7'd0;
    logic       fan_pwm, compressor_on, ramping;
    logic [7:0] duty;
    int n_tests = 0;
    int n_fail = 0;
    fan_driver #(.RAMP_DIV(RD), .MIN_OFF(MO)) dut (
        .clk           (clk),
        .reset         (reset),
        .fan_speed     (fan_speed),
        .fan_heat      (fan_heat),
        .coil_temp     (coil_temp),
        .fan_pwm       (fan_pwm),
        .duty          (duty),
        .compressor_on (compressor_on),
        .ramping       (ramping)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    // Model: t counts clocks since reset; ramp ticks every RD clocks, PWM period is t mod 256,
    // compressor lockout measured as clocks elapsed since the last turn-off.
    int m_t, m_duty, m_lat, m_pwm, m_comp, m_ramp, m_tgt, m_off_at;
    bit m_valid = 1'b0;
    always @(posedge clk) begin
        int pos;
        bit on_ok, off_now, nxt;
        if (reset) begin
            m_valid = 1'b1;
            m_t = 0; m_duty = 0; m_lat = 0; m_pwm = 0; m_comp = 0; m_ramp = 0;
            m_off_at = -MO;
        end else begin
            m_tgt = (fan_speed == 0) ? 0 : (fan_speed >= 4) ? 255 : 64 * int'(fan_speed);
            pos = m_t % 256;
            m_pwm = (m_lat == 255 || pos < m_lat) ? 1 : 0;
            if (pos == 255) m_lat = m_duty;
            on_ok = fan_speed != 0 && fan_heat != 0 && m_duty >= 64 &&
                    int'(coil_temp) > int'(fan_heat) && (m_t - m_off_at) >= MO;
            off_now = fan_speed == 0 || fan_heat == 0 || int'(coil_temp) + 1 <= int'(fan_heat);
            nxt = m_comp ? !off_now : on_ok;
            if (m_comp == 1 && !nxt) m_off_at = m_t;
            m_comp = nxt ? 1 : 0;
            if (m_t % RD == RD - 1) m_duty = (m_tgt > m_duty) ? m_duty + 1 : (m_tgt < m_duty) ? m_duty - 1 : m_duty;
            m_ramp = (m_duty != m_tgt) ? 1 : 0;
            m_t++;
        end
        if (m_valid) begin
            #1;
            chk("model_duty", int'(duty), m_duty);
            chk("model_pwm", int'(fan_pwm), m_pwm);
            chk("model_comp", int'(compressor_on), m_comp);
            chk("model_ramping", int'(ramping), m_ramp);
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end
    initial begin
        int hi;
        wait_n(2);
        chk("rst_duty", int'(duty), 0);
        chk("rst_pwm", int'(fan_pwm), 0);
        chk("rst_comp", int'(compressor_on), 0);
        chk("rst_ramping", int'(ramping), 0);
        reset = 1'b0; fan_speed = 3'd2;
        wait_n(511);
        chk("s1_duty_511", int'(duty), 127);
        chk("s1_ramping_511", int'(ramping), 1);
        wait_n(1);
        chk("s1_duty_512", int'(duty), 128);
        chk("s1_ramping_512", int'(ramping), 0);
        wait_n(300);
        hi = 0;
        repeat (256) begin @(negedge clk); hi += int'(fan_pwm); end
        chk("s1_pwm_high", hi, 128);
        fan_speed = 3'd0; fan_heat = 8'd0; coil_temp = 7'd0;
        pulse_reset();
        fan_speed = 3'd4; fan_heat = 8'd20; coil_temp = 7'd25;
        wait_n(256);
        chk("s2_duty_256", int'(duty), 64);
        chk("s2_comp_256", int'(compressor_on), 0);
        wait_n(1);
        chk("s2_comp_257", int'(compressor_on), 1);
        coil_temp = 7'd19;
        wait_n(1);
        chk("s3_comp_off", int'(compressor_on), 0);
        wait_n(5);
        coil_temp = 7'd25;
        wait_n(26);
        chk("s3_locked", int'(compressor_on), 0);
        wait_n(1);
        chk("s3_relaunch", int'(compressor_on), 1);
        fan_speed = 3'd0; fan_heat = 8'd0; coil_temp = 7'd0;
        pulse_reset();
        fan_speed = 3'd4;
        wait_n(400);
        chk("s4_duty_400", int'(duty), 100);
        chk("s4_ramping_400", int'(ramping), 1);
        fan_speed = 3'd1;
        wait_n(4);
        chk("s4_duty_down", int'(duty), 99);
        chk("s4_ramping_down", int'(ramping), 1);
        wait_n(139);
        chk("s4_duty_65", int'(duty), 65);
        wait_n(1);
        chk("s4_duty_64", int'(duty), 64);
        chk("s4_run", int'(ramping), 0);
        fan_speed = 3'd0;
        pulse_reset();
        fan_speed = 3'd4; fan_heat = 8'd20; coil_temp = 7'd25;
        wait_n(1020);
        chk("s5_duty_255", int'(duty), 255);
        chk("s5_comp_on", int'(compressor_on), 1);
        fan_speed = 3'd0;
        wait_n(1);
        chk("s5_comp_off", int'(compressor_on), 0);
        wait_n(1018);
        chk("s5_duty_1", int'(duty), 1);
        chk("s5_ramping_1", int'(ramping), 1);
        wait_n(1);
        chk("s5_duty_0", int'(duty), 0);
        chk("s5_off", int'(ramping), 0);
        wait_n(300);
        hi = 0;
        repeat (256) begin @(negedge clk); hi += int'(fan_pwm); end
        chk("s5_pwm_zero", hi, 0);
        fan_heat = 8'd30; coil_temp = 7'd40;
        pulse_reset();
        fan_speed = 3'd7;
        wait_n(1020);
        chk("s6_duty_255", int'(duty), 255);
        chk("s6_comp_on", int'(compressor_on), 1);
        wait_n(260);
        hi = 0;
        repeat (256) begin @(negedge clk); hi += int'(fan_pwm); end
        chk("s6_pwm_full", hi, 256);
        reset = 1'b1;
        wait_n(1);
        chk("s6_rst_duty", int'(duty), 0);
        chk("s6_rst_pwm", int'(fan_pwm), 0);
        chk("s6_rst_comp", int'(compressor_on), 0);
        chk("s6_rst_ramping", int'(ramping), 0);
        reset = 1'b0;
        wait_n(256);
        chk("s6_duty_64", int'(duty), 64);
        chk("s6_comp_wait", int'(compressor_on), 0);
        wait_n(1);
        chk("s6_comp_nolock", int'(compressor_on), 1);
        wait_n(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
